// File: rtl/l1c_axi_bridge.sv
// L1 cache miss/write-through responder: one cache request -> one AXI4 transaction (read burst or single-beat write).
// Latency: AR/AW+W issued 1 cycle after I_req seen in IDLE; each R beat / B response -> I_wait=0 pulse 1 cycle later.
// Backpressure: VALIDs held until READY; RREADY/BREADY asserted only while waiting for data/response; no request queuing.
// Optional feature: define L1C_BRIDGE_ERR_EN to add the sticky bus_err output (non-OKAY RRESP/BRESP).
module l1c_axi_bridge #(
  parameter int                BURST_LEN = 4,
  parameter int                ID_W      = 4,
  parameter logic [ID_W-1:0]   AXI_ID    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  // cache side
  input  logic                 I_req,
  input  logic [31:0]          I_addr,
  input  logic                 I_write,
  input  logic [31:0]          I_in,
  input  logic [2:0]           I_type,
  output logic [31:0]          I_out,
  output logic                 I_wait,
`ifdef L1C_BRIDGE_ERR_EN
  output logic                 bus_err,
`endif
  // AXI read address
  output logic [ID_W-1:0]      ARID,
  output logic [31:0]          ARADDR,
  output logic [7:0]           ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  // AXI read data
  input  logic [ID_W-1:0]      RID,
  input  logic [31:0]          RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY,
  // AXI write address
  output logic [ID_W-1:0]      AWID,
  output logic [31:0]          AWADDR,
  output logic [7:0]           AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  // AXI write data
  output logic [31:0]          WDATA,
  output logic [3:0]           WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,
  // AXI write response
  input  logic [ID_W-1:0]      BID,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY
);

  // Cache access-type encoding (matches the cache's CACHE_* definitions)
  localparam logic [2:0] TYPE_BYTE    = 3'b000;
  localparam logic [2:0] TYPE_HWORD   = 3'b001;
  localparam logic [2:0] TYPE_WORD    = 3'b010;
  localparam logic [2:0] TYPE_BYTE_U  = 3'b100;
  localparam logic [2:0] TYPE_HWORD_U = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        i_wait_q, i_wait_d;
  logic [31:0] i_out_q, i_out_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  type_q, type_d;
  logic        err_q, err_d;

  // Next-state / registered-output computation for the transaction FSM
  always_comb begin
    state_d   = state_q;
    i_wait_d  = 1'b1;
    i_out_d   = i_out_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    addr_d    = addr_q;
    data_d    = data_q;
    type_d    = type_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (I_req) begin
          addr_d = I_addr;
          data_d = I_in;
          type_d = I_type;
          if (I_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          i_out_d  = RDATA;
          i_wait_d = 1'b0;
          // RLAST, not a beat count, closes the burst
          if (RLAST) begin
            rready_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once neither is outstanding
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          bready_d = 1'b0;
          i_wait_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        // cache is still holding I_req while it consumes the final pulse
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef L1C_BRIDGE_ERR_EN
    if ((rready_q && RVALID && (RRESP != 2'b00)) ||
        (bready_q && BVALID && (BRESP != 2'b00)))
      err_d = 1'b1;
`endif
  end

  // State and output registers; reset abandons any AXI transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_wait_q  <= 1'b1;
      i_out_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      type_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_wait_q  <= i_wait_d;
      i_out_q   <= i_out_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      type_q    <= type_d;
      err_q     <= err_d;
    end
  end

  // Byte-lane strobes from the latched access type and low address bits
  always_comb begin
    case (type_q)
      TYPE_WORD:                 WSTRB = 4'b1111;
      TYPE_HWORD, TYPE_HWORD_U:  WSTRB = 4'b0011 << {addr_q[1], 1'b0};
      TYPE_BYTE, TYPE_BYTE_U:    WSTRB = 4'b0001 << addr_q[1:0];
      default:                   WSTRB = 4'b0000;
    endcase
  end

  assign I_out   = i_out_q;
  assign I_wait  = i_wait_q;

  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(BURST_LEN - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;
  assign WDATA   = data_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

`ifdef L1C_BRIDGE_ERR_EN
  assign bus_err = err_q;
  logic unused_ids;
  assign unused_ids = ^{RID, BID};
`else
  // response codes and IDs are not inspected without the error feature
  logic unused_resp;
  assign unused_resp = ^{RID, BID, RRESP, BRESP, err_q};
`endif

endmodule

// File: tb/tb_l1c_axi_bridge.sv
// Testbench for l1c_axi_bridge: directed cache requests against a scripted AXI slave.
// Expected pulses / AXI handshakes are queued by the stimulus and checked by an independent monitor.
// Slave readiness is scripted per test to exercise back-to-back, gapped and skewed handshakes.
module tb_l1c_axi_bridge;

  localparam logic [2:0] T_BYTE    = 3'b000;
  localparam logic [2:0] T_HWORD   = 3'b001;
  localparam logic [2:0] T_WORD    = 3'b010;
  localparam logic [2:0] T_HWORD_U = 3'b101;
  localparam logic [2:0] T_OTHER   = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        I_req = 1'b0;
  logic [31:0] I_addr = '0;
  logic        I_write = 1'b0;
  logic [31:0] I_in = '0;
  logic [2:0]  I_type = '0;
  logic [31:0] I_out;
  logic        I_wait;
`ifdef L1C_BRIDGE_ERR_EN
  logic        bus_err;
`endif
  logic [3:0]  ARID, AWID;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;
  logic        RLAST = 1'b0, RVALID = 1'b0, BVALID = 1'b0;

  l1c_axi_bridge #(.BURST_LEN(4), .ID_W(4), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
`ifdef L1C_BRIDGE_ERR_EN
    .bus_err(bus_err),
`endif
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(4'h0), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(4'h0), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd;
    logic [31:0] dat;
    int          cyc;
  } pulse_t;

  pulse_t      pq[$];
  logic [31:0] arq[$];
  logic [31:0] awq[$];
  logic [35:0] wq[$];   // {strb, data}

  int checks = 0;
  int fails  = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: every pulse / handshake the DUT presents must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (!I_wait) begin
        if (pq.size() == 0) fail_now("unexpected_pulse");
        else begin
          pulse_t p;
          p = pq.pop_front();
          chk("pulse_cycle", cyc, p.cyc);
          chk(p.rd ? "rd_I_out" : "wr_I_out", I_out, p.dat);
        end
      end
      if (ARVALID && ARREADY) begin
        if (arq.size() == 0) fail_now("unexpected_ar");
        else begin
          chk("ARADDR", ARADDR, arq.pop_front());
          chk("ARLEN", 32'(ARLEN), 32'd3);
          chk("ARSIZE_BURST", {27'd0, ARSIZE, ARBURST}, {27'd0, 3'b010, 2'b01});
        end
      end
      if (AWVALID && AWREADY) begin
        if (awq.size() == 0) fail_now("unexpected_aw");
        else begin
          chk("AWADDR", AWADDR, awq.pop_front());
          chk("AWLEN", 32'(AWLEN), 32'd0);
        end
      end
      if (WVALID && WREADY) begin
        if (wq.size() == 0) fail_now("unexpected_w");
        else begin
          logic [35:0] w;
          w = wq.pop_front();
          chk("WDATA", WDATA, w[31:0]);
          chk("WSTRB", 32'(WSTRB), 32'(w[35:32]));
          chk("WLAST", 32'(WLAST), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rready();
    for (int i = 0; i < 10 && !RREADY; i++) tick();
    if (!RREADY) fail_now("timeout_rready");
  endtask

  task automatic wait_bready();
    for (int i = 0; i < 10 && !BREADY; i++) tick();
    if (!BREADY) fail_now("timeout_bready");
  endtask

  // 4-beat read; optional RVALID gap after beat 1; optionally hold I_req through DONE
  task automatic do_read(input logic [31:0] a, input logic [31:0] base, input int gap, input bit hold);
    pulse_t p;
    I_req = 1'b1; I_addr = a; I_write = 1'b0; I_type = T_WORD; ARREADY = 1'b1;
    arq.push_back(a);
    tick();
    if (!hold) I_req = 1'b0;
    wait_rready();
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b1; RDATA = base + 32'(i); RLAST = (i == 3); RRESP = 2'b00;
      p.rd = 1'b1; p.dat = base + 32'(i); p.cyc = cyc + 1;
      pq.push_back(p);
      tick();
      if (i == 1 && gap > 0) begin
        RVALID = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_I_wait", 32'(I_wait), 32'd1);
          chk("gap_I_out", I_out, base + 32'd1);
        end
      end
    end
    RVALID = 1'b0; RLAST = 1'b0;
    last_rd = base + 32'd3;
    tick();            // DONE cycle carries the final pulse
    I_req = 1'b0;
    repeat (3) tick();
    chk("idle_no_ar", 32'(ARVALID), 32'd0);
  endtask

  // single-beat write with both channels ready
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t, input logic [3:0] strb);
    pulse_t p;
    awq.push_back(a);
    wq.push_back({strb, d});
    AWREADY = 1'b1; WREADY = 1'b1;
    I_req = 1'b1; I_addr = a; I_write = 1'b1; I_in = d; I_type = t;
    tick();
    I_req = 1'b0;
    wait_bready();
    BVALID = 1'b1;
    p.rd = 1'b0; p.dat = last_rd; p.cyc = cyc + 1;
    pq.push_back(p);
    tick();
    BVALID = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_t p;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_I_wait", 32'(I_wait), 32'd1);
    chk("rst_I_out", I_out, 32'd0);
    chk("rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: back-to-back read burst
    do_read(32'h0000_1040, 32'hA0, 0, 1'b0);
    // 2: read with 3-cycle RVALID gap after beat 1
    do_read(32'h0000_1080, 32'hA0, 3, 1'b0);
    // 3: byte write to lane 3
    do_write(32'h0000_2003, 32'hDD00_0000, T_BYTE, 4'b1000);

    // 4: halfword write, AW accepted 2 cycles before W
    awq.push_back(32'h0000_2002);
    wq.push_back({4'b1100, 32'hBEEF_0000});
    AWREADY = 1'b1; WREADY = 1'b0;
    I_req = 1'b1; I_addr = 32'h0000_2002; I_write = 1'b1; I_in = 32'hBEEF_0000; I_type = T_HWORD;
    tick();
    I_req = 1'b0;
    chk("t4_both_valid", {30'd0, AWVALID, WVALID}, 32'b11);
    tick();
    chk("t4_aw_dropped", {30'd0, AWVALID, WVALID}, 32'b01);
    tick();
    chk("t4_w_held", {30'd0, AWVALID, WVALID}, 32'b01);
    WREADY = 1'b1;
    tick();
    chk("t4_w_dropped", {29'd0, AWVALID, WVALID, BREADY}, 32'b001);
    BVALID = 1'b1;
    p.rd = 1'b0; p.dat = last_rd; p.cyc = cyc + 1;
    pq.push_back(p);
    tick();
    BVALID = 1'b0;
    repeat (3) tick();

    // 5: I_req held through DONE must not start a second read
    do_read(32'h0000_10C0, 32'hC0, 0, 1'b1);

    // 6: reset in RD_DATA after two beats (first beat carries SLVERR)
    I_req = 1'b1; I_addr = 32'h0000_1100; I_write = 1'b0; I_type = T_WORD; ARREADY = 1'b1;
    arq.push_back(32'h0000_1100);
    tick();
    I_req = 1'b0;
    wait_rready();
    for (int i = 0; i < 2; i++) begin
      RVALID = 1'b1; RDATA = 32'hB0 + 32'(i); RRESP = (i == 0) ? 2'b10 : 2'b00;
      p.rd = 1'b1; p.dat = 32'hB0 + 32'(i); p.cyc = cyc + 1;
      pq.push_back(p);
      tick();
    end
    RVALID = 1'b0; RRESP = 2'b00;
    tick();
    chk("t6_rready_before", 32'(RREADY), 32'd1);
`ifdef L1C_BRIDGE_ERR_EN
    chk("t6_bus_err_set", 32'(bus_err), 32'd1);
`endif
    rst = 1'b1;
    #1;
    chk("t6_rst_I_wait", 32'(I_wait), 32'd1);
    chk("t6_rst_rready", 32'(RREADY), 32'd0);
    chk("t6_rst_I_out", I_out, 32'd0);
`ifdef L1C_BRIDGE_ERR_EN
    chk("t6_bus_err_clr", 32'(bus_err), 32'd0);
`endif
    tick();
    rst = 1'b0;
    last_rd = 32'd0;
    tick();

    // recovery writes: word, unsigned halfword, unsupported type
    do_write(32'h0000_3000, 32'h1234_5678, T_WORD, 4'b1111);
    do_write(32'h0000_3000, 32'h0000_5678, T_HWORD_U, 4'b0011);
    do_write(32'h0000_3001, 32'h0000_9900, T_OTHER, 4'b0000);

    repeat (5) tick();
    chk("pulse_q_empty", 32'(pq.size()), 32'd0);
    chk("ar_q_empty", 32'(arq.size()), 32'd0);
    chk("aw_w_q_empty", 32'(awq.size() + wq.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
